// File: rtl/snitch_icache_pkg.sv
// Shared types for the L0 instruction-cache event counters: the per-port
// event strobe bundle and the counter index enum.
package snitch_icache_pkg;

  localparam int NUM_ICACHE_EVENTS = 5;

  // Last field is the LSB, so bit k of the packed struct is counter index k.
  typedef struct packed {
    logic l0_miss;        // bit 4
    logic l0_hit;         // bit 3
    logic l0_prefetch;    // bit 2
    logic l0_double_hit;  // bit 1
    logic l0_stall;       // bit 0
  } icache_events_t;

  typedef enum logic [2:0] {
    EVT_L0_STALL      = 3'd0,
    EVT_L0_DOUBLE_HIT = 3'd1,
    EVT_L0_PREFETCH   = 3'd2,
    EVT_L0_HIT        = 3'd3,
    EVT_L0_MISS       = 3'd4
  } icache_event_idx_e;

endpackage

// File: rtl/snitch_icache_event_ctr.sv
// One event counter: adds a small zero-extended increment each enabled cycle,
// either wrapping or clamping at all-ones, with a sticky overflow flag.
module snitch_icache_event_ctr #(
  parameter int CNT_WIDTH = 32,
  parameter int INC_WIDTH = 3,
  parameter int SATURATE  = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic [INC_WIDTH-1:0] inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 ovf_o
);

  localparam int PAD_WIDTH = CNT_WIDTH + 1 - INC_WIDTH;

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_ovf;
  logic [CNT_WIDTH:0]   w_sum;

  // One extra bit on the sum exposes the carry out of the counter.
  assign w_sum = {1'b0, r_cnt} + {{PAD_WIDTH{1'b0}}, inc_i};

  // Counter and sticky overflow; clear wins over counting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (clr_i) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (en_i) begin
      if (w_sum[CNT_WIDTH]) begin
        r_ovf <= 1'b1;
      end
      if ((SATURATE != 0) && w_sum[CNT_WIDTH]) begin
        r_cnt <= {CNT_WIDTH{1'b1}};
      end else begin
        r_cnt <= w_sum[CNT_WIDTH-1:0];
      end
    end
  end

  assign cnt_o = r_cnt;
  assign ovf_o = r_ovf;

endmodule

// File: rtl/snitch_icache_event_counters.sv
// Aggregates per-port L0 icache event strobes into one live counter per event
// type, with a snapshot (shadow) bank and a one-cycle-latency read port.
// Read handshake: rd_gnt_o mirrors rd_req_i, so a request is accepted in the
// cycle it is raised; rd_rvalid_o pulses exactly one cycle later with the
// bank value sampled at the start of the accepting cycle.
module snitch_icache_event_counters
  import snitch_icache_pkg::*;
#(
  parameter int NR_FETCH_PORTS = 4,
  parameter int CNT_WIDTH      = 32,
  parameter int SATURATE       = 0
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                enable_i,
  input  logic                                clear_i,
  input  logic                                snapshot_i,
  input  icache_events_t [NR_FETCH_PORTS-1:0] events_i,
  input  logic                                rd_req_i,
  input  logic [2:0]                          rd_addr_i,
  input  logic                                rd_shadow_i,
  output logic                                rd_gnt_o,
  output logic                                rd_rvalid_o,
  output logic [CNT_WIDTH-1:0]                rd_rdata_o,
  output logic [NUM_ICACHE_EVENTS-1:0]        overflow_o
);

  localparam int INC_WIDTH = $clog2(NR_FETCH_PORTS + 1);

  logic [NUM_ICACHE_EVENTS-1:0] w_evt_vec [NR_FETCH_PORTS];
  logic [INC_WIDTH-1:0]         w_inc     [NUM_ICACHE_EVENTS];
  logic [CNT_WIDTH-1:0]         w_cnt     [NUM_ICACHE_EVENTS];
  logic [CNT_WIDTH-1:0]         r_shadow  [NUM_ICACHE_EVENTS];
  logic [CNT_WIDTH-1:0]         w_rd_val;
  logic                         r_rvalid;
  logic [CNT_WIDTH-1:0]         r_rdata;

  for (genvar p = 0; p < NR_FETCH_PORTS; p++) begin : gen_evt_vec
    assign w_evt_vec[p] = events_i[p];
  end

  // Popcount of each event type across all fetch ports.
  always_comb begin
    for (int k = 0; k < NUM_ICACHE_EVENTS; k++) begin
      w_inc[k] = '0;
      for (int p = 0; p < NR_FETCH_PORTS; p++) begin
        w_inc[k] = w_inc[k] + INC_WIDTH'(w_evt_vec[p][k]);
      end
    end
  end

  for (genvar k = 0; k < NUM_ICACHE_EVENTS; k++) begin : gen_ctr
    snitch_icache_event_ctr #(
      .CNT_WIDTH (CNT_WIDTH),
      .INC_WIDTH (INC_WIDTH),
      .SATURATE  (SATURATE)
    ) u_ctr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (enable_i),
      .clr_i  (clear_i),
      .inc_i  (w_inc[k]),
      .cnt_o  (w_cnt[k]),
      .ovf_o  (overflow_o[k])
    );
  end

  // Shadow bank captures pre-update live values; clear never touches it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_ICACHE_EVENTS; k++) r_shadow[k] <= '0;
    end else if (snapshot_i) begin
      for (int k = 0; k < NUM_ICACHE_EVENTS; k++) r_shadow[k] <= w_cnt[k];
    end
  end

  // Read mux: addresses beyond the last counter return zero.
  always_comb begin
    w_rd_val = '0;
    for (int k = 0; k < NUM_ICACHE_EVENTS; k++) begin
      if (rd_addr_i == 3'(k)) begin
        w_rd_val = rd_shadow_i ? r_shadow[k] : w_cnt[k];
      end
    end
  end

  // Read response register; data only moves when a request is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= rd_req_i;
      if (rd_req_i) begin
        r_rdata <= w_rd_val;
      end
    end
  end

  assign rd_gnt_o    = rd_req_i;
  assign rd_rvalid_o = r_rvalid;
  assign rd_rdata_o  = r_rdata;

endmodule

// File: doc/snitch_icache_event_counters.md
SNITCH_ICACHE_EVENT_COUNTERS -- requirements
Module: snitch_icache_event_counters

Interface
REQ-001 SHALL have parameter NR_FETCH_PORTS, default 4: number of fetch ports whose events are aggregated; legal range 1..32.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of each counter; legal range 8..64.
REQ-003 SHALL have parameter SATURATE, default 0: 0 means counters wrap, 1 means counters clamp at all-ones.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port enable_i, input, 1 bit: counting enable.
REQ-007 SHALL have port clear_i, input, 1 bit: single-cycle pulse that zeroes all live counters and overflow flags.
REQ-008 SHALL have port snapshot_i, input, 1 bit: single-cycle pulse that copies the live counters into the shadow bank.
REQ-009 SHALL have port events_i, input, NR_FETCH_PORTS x icache_events_t: per-port, per-cycle event strobes.
REQ-010 SHALL have port rd_req_i, input, 1 bit: read request.
REQ-011 SHALL have port rd_addr_i, input, 3 bits: counter index.
REQ-012 SHALL have port rd_shadow_i, input, 1 bit: selects the shadow bank (1) or the live bank (0).
REQ-013 SHALL have port rd_gnt_o, output, 1 bit: read grant.
REQ-014 SHALL have port rd_rvalid_o, output, 1 bit: read data valid.
REQ-015 SHALL have port rd_rdata_o, output, CNT_WIDTH bits: read data.
REQ-016 SHALL have port overflow_o, output, NUM_ICACHE_EVENTS bits: sticky per-counter overflow flags.

Function
REQ-017 SHALL keep one live counter per icache_events_t field, indexed 0=l0_stall, 1=l0_double_hit, 2=l0_prefetch, 3=l0_hit, 4=l0_miss, which is bit order LSB first.
REQ-018 SHALL, in each cycle with enable_i=1, add to counter k the popcount of field k across all ports; the increment is $clog2(NR_FETCH_PORTS+1) bits wide and zero-extended.
REQ-019 SHALL, with SATURATE=0, wrap each counter modulo 2^CNT_WIDTH and set overflow_o[k] when the addition carries out.
REQ-020 SHALL, with SATURATE=1, clamp each counter at 2^CNT_WIDTH-1 and set overflow_o[k] when the true sum exceeds that value.
REQ-021 SHALL hold counters unchanged while enable_i=0 and drop those events without buffering them.
REQ-022 SHALL give clear_i priority over counting: the counters read 0 on the next cycle and events of the clear cycle are discarded.
REQ-023 SHALL make the shadow bank capture the live values from before the current cycle's update when snapshot_i=1; this includes a cycle where clear_i is also 1.
REQ-024 SHALL leave the shadow bank unaffected by clear_i.
REQ-025 SHALL drive rd_gnt_o = rd_req_i combinationally, so every request is accepted the same cycle.
REQ-026 SHALL assert rd_rvalid_o exactly one cycle after an accepted request, with rd_rdata_o registered.
REQ-027 SHALL return, for a read accepted in cycle t, the bank value at the start of cycle t (pre-increment, pre-clear).
REQ-028 SHALL return 0 with rd_rvalid_o=1 for rd_addr_i >= NUM_ICACHE_EVENTS.
REQ-029 SHALL hold rd_rdata_o stable while rd_rvalid_o=0.

Reset
REQ-030 SHALL reset asynchronously on rst_ni low: live counters, shadow bank, overflow_o, rd_rvalid_o and rd_rdata_o all become 0.
REQ-031 SHALL drop any read in flight when reset is asserted mid-operation, with no rd_rvalid_o after reset is released.

Structure
REQ-032 SHALL take NUM_ICACHE_EVENTS (=5) and the counter-index enum from snitch_icache_pkg, alongside icache_events_t.
REQ-033 SHALL implement one counter as sub-module snitch_icache_event_ctr (parameters CNT_WIDTH, INC_WIDTH, SATURATE), instantiated NUM_ICACHE_EVENTS times.

Verification
REQ-034 SHALL cover: NR_FETCH_PORTS=4, l0_hit on all 4 ports for 3 enabled cycles -> live counter 3 = 12, other counters 0.
REQ-035 SHALL cover: CNT_WIDTH=8, SATURATE=0, counter 4 at 254, 3 ports miss -> counter 4 = 1, overflow_o[4]=1.
REQ-036 SHALL cover: CNT_WIDTH=8, SATURATE=1, counter 4 at 254, 3 ports miss -> counter 4 = 255, overflow_o[4]=1, unchanged on further misses.
REQ-037 SHALL cover: counter 0 = 7, with snapshot_i, clear_i and one l0_stall in the same cycle -> shadow[0] = 7, live[0] = 0 next cycle.
REQ-038 SHALL cover: read of addr 3 issued in the same cycle as a +2 increment from 10 -> rd_rvalid_o the next cycle with rd_rdata_o = 10; read of addr 6 -> rd_rdata_o = 0 with rd_rvalid_o=1.
REQ-039 SHALL cover: rst_ni asserted the cycle after rd_req_i -> no rd_rvalid_o, and all counters and flags read 0 after reset.
